video_timing_mixer: RTL and testbench
=====================================

Name: video_timing_mixer

Overview:
- Display-side end of the sprite pixel interface. Generates the 640x480@60 raster (hcount, vcount, enable) that the ball and paddle blocks sample.
- Collects each source's registered RGB332 and layer output and resolves priority into one pixel.
- Drives the aligned VGA colour and sync pins.

Parameters:
- CLK_DIV, 2, clock cycles per pixel; must be >=2 so sources can register their answer within one pixel.
- H_ACTIVE, 640, H_FP, 16, H_SYNC, 96, H_BP, 48: horizontal timing in pixels; H_TOTAL = sum = 800.
- V_ACTIVE, 480, V_FP, 10, V_SYNC, 2, V_BP, 33: vertical timing in lines; V_TOTAL = 525.
- BG_COLOR, 8'h00, {red,green,blue} shown where no source is opaque.

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- enable  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE
- frame_start  out  1  one-clock pulse on the pixel tick where hcount and vcount both become 0
- src0_red/src0_green/src0_blue  in  3/3/2  source 0 colour (registered by source)
- src0_layer  in  1  source 0 layer: 1 = foreground, 0 = background
- src1_red/src1_green/src1_blue/src1_layer  in  3/3/2/1  source 1, same meaning
- vga_red/vga_green/vga_blue  out  3/3/2  mixed pixel
- vga_hsync, vga_vsync  out  1  active-low syncs
- vga_de  out  1  delayed enable, aligned with vga_* colour

Behaviour:
- Reset (resetn=0, async): divider=0, hcount=0, vcount=0, enable=0, frame_start=0, vga_* colour=0, vga_hsync=1, vga_vsync=1, vga_de=0. Release is synchronised internally; counting starts on the first clock after release.
- Pixel tick: internal divider counts 0..CLK_DIV-1. Tick = divider==CLK_DIV-1. All raster and output registers update only on a tick, except frame_start, which clears on the next clock.
- Raster: on tick, hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount wraps from V_TOTAL-1 to 0 on the same tick that hcount wraps.
- enable is registered from the next-state counters, so it is consistent with hcount/vcount in the same cycle.
- Sync decode, before alignment:
  - hsync_n=0 for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_n=0 for vcount 490..491.
- Alignment: sources answer one clock after hcount/vcount change. The mixer samples src* on the next tick, so vga_* colour describes the previous pixel. vga_hsync, vga_vsync and vga_de are the pre-alignment signals delayed by exactly one tick, giving total latency of 1 pixel from raster to pins.
- Opacity: a source is opaque when its 8-bit colour is nonzero.
- Priority, sampled on tick:
  1. src0 opaque and layer=1
  2. src1 opaque and layer=1
  3. src0 opaque and layer=0
  4. src1 opaque and layer=0
  5. BG_COLOR
- Colour outputs: vga_* colour = 0 whenever the delayed enable is 0, regardless of sources.
- No arithmetic overflow: counters are 10 bits and the maximum value is 799.

Test Plan:
- Reset then run 2*800*525 clocks -> frame_start pulses exactly once per 840000 clocks; first pulse when hcount=0, vcount=0 following the wrap; vga_hsync low for 96 ticks per line; vga_vsync low for 1600 ticks per frame.
- Both sources drive 0 with BG_COLOR=8'h03 -> vga_de=1 for 640 ticks per line, colour=8'h03 during vga_de, 0 elsewhere; 480 active lines per frame.
- Alignment: src0 returns 8'hFF only when it saw hcount==100,vcount==50 (one clock later) -> exactly one pixel of 8'hFF on the pins, on the tick where the raster reads hcount=101, vcount=50.
- Priority: src0=8'h1C layer0, src1=8'hE0 layer1 -> output 8'hE0. Both layer1 -> 8'h1C. src0=8'h00 layer1, src1=8'h03 layer0 -> 8'h03.
- Boundary: src0 constant 8'hFF -> colour 0 at hcount 640..799 (delayed) and lines 480..524; hcount 799->0 increments vcount; vcount 524->0 at line wrap.
- Mid-frame reset: assert resetn=0 at hcount=300,vcount=200 -> all outputs go to reset values asynchronously in the same cycle; after release, raster restarts at 0,0 with a full first frame.

Source files
------------

// File: rtl/video_timing_mixer.sv
// rtl/video_timing_mixer.sv - VGA raster generator, two-source priority mixer and aligned pin stage
module video_timing_mixer #(
  parameter int          CLK_DIV  = 2,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic       clock,
  input  logic       resetn,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       enable,
  output logic       frame_start,
  input  logic [2:0] src0_red,
  input  logic [2:0] src0_green,
  input  logic [1:0] src0_blue,
  input  logic       src0_layer,
  input  logic [2:0] src1_red,
  input  logic [2:0] src1_green,
  input  logic [1:0] src1_blue,
  input  logic       src1_layer,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic             run_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             active_now;
  logic             hsync_pre_n;
  logic             vsync_pre_n;
  logic [7:0]       src0_color;
  logic [7:0]       src1_color;
  logic             src0_opaque;
  logic             src1_opaque;
  logic [7:0]       mix_color;
  logic [7:0]       vga_color_q;

  // Release synchroniser: assertion is immediate, counting waits one clock after release
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  assign tick = run_q && (div_q == DIV_LAST);

  // Pixel-rate divider: one tick every CLK_DIV clocks
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    div_q <= '0;
    else if (run_q) div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Next raster position, shared by the counters and the registered enable
  always_comb begin
    h_next = hcount + 10'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end
  end

  // Raster counters and enable, advanced once per pixel tick
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hcount <= '0;
      vcount <= '0;
      enable <= 1'b0;
    end else if (tick) begin
      hcount <= h_next;
      vcount <= v_next;
      enable <= (h_next < H_ACT) && (v_next < V_ACT);
    end
  end

  // Frame start: one clock wide, raised on the tick that lands on (0,0)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) frame_start <= 1'b0;
    else         frame_start <= tick && (h_next == 10'd0) && (v_next == 10'd0);
  end

  // Pre-alignment decode of the current raster position
  assign active_now  = (hcount < H_ACT) && (vcount < V_ACT);
  assign hsync_pre_n = !((hcount >= HS_START) && (hcount < HS_END));
  assign vsync_pre_n = !((vcount >= VS_START) && (vcount < VS_END));

  assign src0_color  = {src0_red, src0_green, src0_blue};
  assign src1_color  = {src1_red, src1_green, src1_blue};
  assign src0_opaque = |src0_color;
  assign src1_opaque = |src1_color;

  // Priority resolve: foreground beats background, source 0 beats source 1 within a layer
  always_comb begin
    mix_color = BG_COLOR;
    if (src0_opaque && src0_layer)      mix_color = src0_color;
    else if (src1_opaque && src1_layer) mix_color = src1_color;
    else if (src0_opaque)               mix_color = src0_color;
    else if (src1_opaque)               mix_color = src1_color;
  end

  // Pin stage: sources have answered for the current pixel, so everything lags the raster by one tick
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_color_q <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_de      <= 1'b0;
    end else if (tick) begin
      vga_color_q <= active_now ? mix_color : 8'h00;
      vga_hsync   <= hsync_pre_n;
      vga_vsync   <= vsync_pre_n;
      vga_de      <= active_now;
    end
  end

  assign {vga_red, vga_green, vga_blue} = vga_color_q;

endmodule

// File: tb/tb_video_timing_mixer.sv
// tb/tb_video_timing_mixer.sv - randomized model-checked bench for video_timing_mixer
module tb_video_timing_mixer;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [7:0] BG = 8'h03;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] hcount, vcount;
  logic       enable, frame_start;
  logic [2:0] src0_red = '0, src0_green = '0, src1_red = '0, src1_green = '0;
  logic [1:0] src0_blue = '0, src1_blue = '0;
  logic       src0_layer = 1'b0, src1_layer = 1'b0;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;
  logic       vga_hsync, vga_vsync, vga_de;

  video_timing_mixer #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BG_COLOR(BG)
  ) dut (
    .clock(clock), .resetn(resetn), .hcount(hcount), .vcount(vcount),
    .enable(enable), .frame_start(frame_start),
    .src0_red(src0_red), .src0_green(src0_green), .src0_blue(src0_blue), .src0_layer(src0_layer),
    .src1_red(src1_red), .src1_green(src1_green), .src1_blue(src1_blue), .src1_layer(src1_layer),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de)
  );

  always #5 clock = ~clock;

  // Per-pixel source answers, {layer, rgb332}, indexed by line*HT+column
  logic [8:0] tab0 [FRAME];
  logic [8:0] tab1 [FRAME];

  int total = 0, bad = 0;
  int e = 0, n = 0, q = 0, p = 0, qh = 0, qv = 0;
  logic [9:0] x_h = '0, x_v = '0;
  logic       x_en = 1'b0, x_fs = 1'b0, x_hs = 1'b1, x_vs = 1'b1, x_de = 1'b0;
  logic [7:0] x_col = '0;
  logic       chk_on = 1'b0;

  int hs_lo, vs_lo, de_cnt, bg_de, leak, ff_cnt, ff_h, ff_v, fs_cnt, fs_first_e, fs_hv;

  function automatic logic [7:0] mix_ref(logic [8:0] a, logic [8:0] b);
    if (a[7:0] != 8'h00 && a[8]) return a[7:0];
    if (b[7:0] != 8'h00 && b[8]) return b[7:0];
    if (a[7:0] != 8'h00) return a[7:0];
    if (b[7:0] != 8'h00) return b[7:0];
    return BG;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_src();
    int idx;
    idx = int'(vcount) * HT + int'(hcount);
    if (idx >= FRAME || idx < 0) idx = 0;
    {src0_layer, src0_red, src0_green, src0_blue} = tab0[idx];
    {src1_layer, src1_red, src1_green, src1_blue} = tab1[idx];
  endtask

  // Sources answer half a clock after the raster moves
  always @(negedge clock) drive_src();

  task automatic set_tables(input int mode);
    for (int i = 0; i < FRAME; i++) begin
      case (mode)
        1: begin
          tab0[i] = {1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom)};
          tab1[i] = {1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom)};
        end
        2: begin tab0[i] = (i == 5 * HT + 10) ? 9'h0FF : 9'h000; tab1[i] = 9'h000; end
        3: begin tab0[i] = 9'h01C; tab1[i] = 9'h1E0; end
        4: begin tab0[i] = 9'h11C; tab1[i] = 9'h1E0; end
        5: begin tab0[i] = 9'h100; tab1[i] = 9'h003; end
        6: begin tab0[i] = {1'($urandom_range(0, 1)), 8'hFF}; tab1[i] = 9'h000; end
        default: begin tab0[i] = 9'h000; tab1[i] = 9'h000; end
      endcase
    end
    drive_src();
  endtask

  task automatic clear_stats();
    hs_lo = 0; vs_lo = 0; de_cnt = 0; bg_de = 0; leak = 0;
    ff_cnt = 0; ff_h = -1; ff_v = -1; fs_cnt = 0; fs_first_e = -1; fs_hv = -1;
  endtask

  // Reference: after tick n the raster sits on pixel n mod FRAME and the pins show pixel n-1
  always @(posedge clock) begin
    if (!resetn) begin
      e = 0; n = 0;
      x_h = '0; x_v = '0; x_en = 1'b0; x_fs = 1'b0;
      x_hs = 1'b1; x_vs = 1'b1; x_de = 1'b0; x_col = '0;
    end else begin
      e++;
      x_fs = 1'b0;
      if (e >= 3 && (e % 2) == 1) begin
        q = n % FRAME;
        n++;
        p = n % FRAME;
        x_h = 10'(p % HT); x_v = 10'(p / HT);
        x_en = (p % HT) < HA && (p / HT) < VA;
        x_fs = (p == 0);
        qh = q % HT; qv = q / HT;
        x_de = qh < HA && qv < VA;
        x_hs = !(qh >= HA + HF && qh < HA + HF + HS);
        x_vs = !(qv >= VA + VF && qv < VA + VF + VS);
        x_col = x_de ? mix_ref(tab0[q], tab1[q]) : 8'h00;
      end
    end
  end

  // Compare every clock away from the active edge, and gather per-tick statistics
  always @(negedge clock) begin
    if (resetn && chk_on) begin
      total++;
      if ({hcount, vcount, enable, frame_start} !== {x_h, x_v, x_en, x_fs}) begin
        bad++;
        if (bad < 30) $display("FAIL raster e=%0d: got h=%0d v=%0d en=%b fs=%b expected h=%0d v=%0d en=%b fs=%b",
                               e, hcount, vcount, enable, frame_start, x_h, x_v, x_en, x_fs);
      end
      total++;
      if ({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, vga_de} !== {x_col, x_hs, x_vs, x_de}) begin
        bad++;
        if (bad < 30) $display("FAIL pins e=%0d: got col=%h hs=%b vs=%b de=%b expected col=%h hs=%b vs=%b de=%b",
                               e, {vga_red, vga_green, vga_blue}, vga_hsync, vga_vsync, vga_de,
                               x_col, x_hs, x_vs, x_de);
      end
      if (e >= 3 && (e % 2) == 1) begin
        if (!vga_hsync) hs_lo++;
        if (!vga_vsync) vs_lo++;
        if (vga_de) de_cnt++;
        if (vga_de && {vga_red, vga_green, vga_blue} == BG) bg_de++;
        if (!vga_de && {vga_red, vga_green, vga_blue} != 8'h00) leak++;
        if ({vga_red, vga_green, vga_blue} == 8'hFF) begin
          ff_cnt++; ff_h = int'(hcount); ff_v = int'(vcount);
        end
      end
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) begin fs_first_e = e; fs_hv = int'({hcount, vcount}); end
      end
    end
  end

  task automatic settle_and_window();
    repeat (4) @(negedge clock);
    #1 clear_stats();
    repeat (2 * FRAME) @(negedge clock);
    #1;
  endtask

  task automatic prio_case(input int mode, input string name, input int exp);
    set_tables(mode);
    repeat (4) @(negedge clock);
    for (int i = 0; i < 2 * FRAME && !vga_de; i++) @(negedge clock);
    chk(name, int'({vga_red, vga_green, vga_blue}), exp);
  endtask

  initial begin
    set_tables(0);
    clear_stats();
    repeat (3) @(negedge clock);
    chk("reset_raster", int'({hcount, vcount, enable, frame_start}), 0);
    chk("reset_pins", int'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, vga_de}), 6);

    // Two frames of background only from release
    resetn = 1'b1;
    chk_on = 1'b1;
    repeat (4 * FRAME + 2) @(negedge clock);
    #1;
    chk("fs_count", fs_cnt, 2);
    chk("fs_first_clock", fs_first_e, 851);
    chk("fs_first_pos", fs_hv, 0);
    chk("hsync_low_ticks", hs_lo, 2 * VT * HS);
    chk("vsync_low_ticks", vs_lo, 2 * HT * VS);
    chk("de_ticks", de_cnt, 2 * HA * VA);
    chk("bg_during_de", bg_de, 2 * HA * VA);
    chk("blank_leak_bg", leak, 0);

    // Random sources over two frames, checked by the model alone
    set_tables(1);
    settle_and_window();
    set_tables(1);
    settle_and_window();

    // Single-pixel answer lands one pixel later on the pins
    set_tables(2);
    settle_and_window();
    chk("align_count", ff_cnt, 1);
    chk("align_h", ff_h, 11);
    chk("align_v", ff_v, 5);

    // Priority literals
    prio_case(3, "prio_fg1_over_bg0", 8'hE0);
    prio_case(4, "prio_both_fg", 8'h1C);
    prio_case(5, "prio_clear_fg", 8'h03);

    // Constant opaque source is masked outside the active area
    set_tables(6);
    settle_and_window();
    chk("mask_ff_ticks", ff_cnt, HA * VA);
    chk("mask_leak", leak, 0);

    // Mid-frame asynchronous reset, then a full first frame
    set_tables(1);
    begin
      int found;
      found = 0;
      for (int i = 0; i < 4 * FRAME && found == 0; i++) begin
        @(negedge clock);
        if (hcount == 10'd10 && vcount == 10'd6) found = 1;
      end
      chk("midreset_reached", found, 1);
    end
    #2 resetn = 1'b0;
    #1;
    chk("midreset_raster", int'({hcount, vcount, enable, frame_start}), 0);
    chk("midreset_pins", int'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, vga_de}), 6);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    clear_stats();
    repeat (2 * FRAME + 4) @(negedge clock);
    #1;
    chk("restart_fs_count", fs_cnt, 1);
    chk("restart_fs_clock", fs_first_e, 851);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
